// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MIPS constants: next-PC select codes, opcodes, reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_datapath_if
// Brief    : Control/data bundle between main control and the fetch datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_datapath_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);

  logic             PCWrite;
  logic             Branch;
  logic             NEF;
  logic             Zero;
  logic             IorD;
  logic             IRWrite;
  logic [1:0]       PCSrc;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] MemRdData;

  logic [WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] Instr;
  logic [5:0]       Op;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] SignImm;
  logic [WIDTH-1:0] MemData;
  logic [WIDTH-1:0] ALUOut;
  logic [CNT_W-1:0] FetchCount;
  logic             PCMisalign;

  modport master (
    output PCWrite, Branch, NEF, Zero, IorD, IRWrite, PCSrc, ALUResult, MemRdData,
    input  MemAddr, PC, Instr, Op, Rs, Rt, Rd, Funct, SignImm, MemData, ALUOut,
           FetchCount, PCMisalign
  );

  modport slave (
    input  PCWrite, Branch, NEF, Zero, IorD, IRWrite, PCSrc, ALUResult, MemRdData,
    output MemAddr, PC, Instr, Op, Rs, Rt, Rd, Funct, SignImm, MemData, ALUOut,
           FetchCount, PCMisalign
  );

endinterface : fetch_datapath_if
`default_nettype wire

// File: rtl/en_reg.sv
`default_nettype none
// ============================================================================
// Module   : en_reg
// Brief    : Parameterised-width register with load enable and async low reset.
// Revision : 1.0 - initial release
// ============================================================================
module en_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         en,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : en_reg
`default_nettype wire

// File: rtl/fetch_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fetch_datapath
// Brief    : Multicycle MIPS PC/IR/MDR/ALUOut datapath with decode and debug.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_datapath
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int               CNT_W    = 32
) (
  input wire logic         clk,
  input wire logic         reset,
  fetch_datapath_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_pc_en;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_alu_out;
  logic [CNT_W-1:0] r_fetch_count;
  logic             r_pc_misalign;

  // NEF inverts the branch sense: beq takes on Zero, bne on !Zero.
  assign w_pc_en = bus.PCWrite | (bus.Branch & (bus.Zero ^ bus.NEF));

  always_comb begin
    w_pc_next = r_pc;
    case (bus.PCSrc)
      PCSRC_ALU:    w_pc_next = bus.ALUResult;
      PCSRC_ALUOUT: w_pc_next = r_alu_out;
      PCSRC_JUMP:   w_pc_next = {r_pc[WIDTH-1:28], r_instr[25:0], 2'b00};
      PCSRC_HOLD:   w_pc_next = r_pc;
      default:      w_pc_next = r_pc;
    endcase
  end

  en_reg #(.W(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (w_pc_en),
    .d     (w_pc_next),
    .q     (r_pc)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (bus.IRWrite),
    .d     (bus.MemRdData),
    .q     (r_instr)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_mdr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (bus.MemRdData),
    .q     (r_mdr)
  );

  en_reg #(.W(WIDTH), .RESET_VAL('0)) u_alu_out (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (bus.ALUResult),
    .q     (r_alu_out)
  );

  // Debug state: the counter wraps naturally and the misalign flag is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_pc_misalign <= 1'b0;
    end else begin
      if (bus.IRWrite) begin
        r_fetch_count <= r_fetch_count + C_CNT_ONE;
      end
      if (w_pc_en && (w_pc_next[1:0] != 2'b00)) begin
        r_pc_misalign <= 1'b1;
      end
    end
  end

  assign bus.MemAddr    = bus.IorD ? r_alu_out : r_pc;
  assign bus.PC         = r_pc;
  assign bus.Instr      = r_instr;
  assign bus.Op         = r_instr[31:26];
  assign bus.Rs         = r_instr[25:21];
  assign bus.Rt         = r_instr[20:16];
  assign bus.Rd         = r_instr[15:11];
  assign bus.Funct      = r_instr[5:0];
  assign bus.SignImm    = {{(WIDTH-16){r_instr[15]}}, r_instr[15:0]};
  assign bus.MemData    = r_mdr;
  assign bus.ALUOut     = r_alu_out;
  assign bus.FetchCount = r_fetch_count;
  assign bus.PCMisalign = r_pc_misalign;

endmodule : fetch_datapath
`default_nettype wire

// File: tb/tb_fetch_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_datapath
// Brief    : Directed self-checking bench for fetch_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_datapath;
  import mips_pkg::*;

  localparam int          C_WIDTH    = 32;
  localparam int          C_CNT_W    = 4;
  localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fetch_datapath_if #(.WIDTH(C_WIDTH), .CNT_W(C_CNT_W)) bus ();

  fetch_datapath #(
    .WIDTH    (C_WIDTH),
    .RESET_PC (C_RESET_PC),
    .CNT_W    (C_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.PCWrite   = 1'b0;
    bus.Branch    = 1'b0;
    bus.NEF       = 1'b0;
    bus.Zero      = 1'b0;
    bus.IorD      = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCSrc     = PCSRC_ALU;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle();
    bus.ALUResult = 32'h1234_5678;
    bus.MemRdData = 32'hDEAD_BEEF;
    bus.PCWrite   = 1'b1;
    bus.IRWrite   = 1'b1;

    // Reset held across edges with enables active.
    repeat (3) step();
    chk("rst_pc",      bus.PC,              C_RESET_PC);
    chk("rst_instr",   bus.Instr,           32'h0);
    chk("rst_op",      32'(bus.Op),         32'h0);
    chk("rst_signimm", bus.SignImm,         32'h0);
    chk("rst_mdr",     bus.MemData,         32'h0);
    chk("rst_aluout",  bus.ALUOut,          32'h0);
    chk("rst_cnt",     32'(bus.FetchCount), 32'h0);
    chk("rst_mis",     32'(bus.PCMisalign), 32'h0);
    chk("rst_memaddr", bus.MemAddr,         C_RESET_PC);

    // Fetch cycle.
    @(negedge clk);
    reset         = 1'b1;
    idle();
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.MemRdData = 32'h1043_0003;
    bus.ALUResult = C_RESET_PC + 32'd4;
    #1;
    chk("fetch_memaddr_pre", bus.MemAddr, C_RESET_PC);
    step();
    idle();
    chk("fetch_instr",   bus.Instr,           32'h1043_0003);
    chk("fetch_op",      32'(bus.Op),         32'(OP_BEQ));
    chk("fetch_rs",      32'(bus.Rs),         32'd2);
    chk("fetch_rt",      32'(bus.Rt),         32'd3);
    chk("fetch_signimm", bus.SignImm,         32'd3);
    chk("fetch_pc",      bus.PC,              32'h0040_0004);
    chk("fetch_cnt",     32'(bus.FetchCount), 32'd1);
    chk("fetch_mdr",     bus.MemData,         32'h1043_0003);

    // Load branch target into ALUOut; check address mux on ALUOut.
    bus.ALUResult = 32'h0040_0010;
    step();
    bus.IorD = 1'b1;
    #1;
    chk("aluout",         bus.ALUOut,  32'h0040_0010);
    chk("memaddr_aluout", bus.MemAddr, 32'h0040_0010);
    bus.IorD = 1'b0;

    // beq not taken, then taken.
    bus.Branch = 1'b1; bus.PCSrc = PCSRC_ALUOUT; bus.NEF = 1'b0; bus.Zero = 1'b0;
    step();
    chk("beq_nt_pc", bus.PC, 32'h0040_0004);
    bus.Zero = 1'b1;
    step();
    chk("beq_t_pc", bus.PC, 32'h0040_0010);

    // bne: new target, Zero=1 not taken, Zero=0 taken.
    idle();
    bus.ALUResult = 32'h0040_0020;
    step();
    bus.Branch = 1'b1; bus.PCSrc = PCSRC_ALUOUT; bus.NEF = 1'b1; bus.Zero = 1'b1;
    step();
    chk("bne_nt_pc", bus.PC, 32'h0040_0010);
    bus.Zero = 1'b0;
    step();
    chk("bne_t_pc", bus.PC, 32'h0040_0020);

    // Jump from PC=0x1000_0004 with IR=0x0800_0040.
    idle();
    bus.PCWrite   = 1'b1;
    bus.IRWrite   = 1'b1;
    bus.ALUResult = 32'h1000_0004;
    bus.MemRdData = 32'h0800_0040;
    step();
    chk("j_pre_pc", bus.PC,      32'h1000_0004);
    chk("j_op",     32'(bus.Op), 32'(OP_J));
    idle();
    bus.PCWrite   = 1'b1;
    bus.PCSrc     = PCSRC_JUMP;
    bus.ALUResult = 32'h0;
    step();
    chk("j_pc",  bus.PC,              32'h1000_0100);
    chk("j_cnt", 32'(bus.FetchCount), 32'd2);
    chk("j_mis", 32'(bus.PCMisalign), 32'd0);

    // Misaligned load sets the sticky flag.
    bus.PCSrc     = PCSRC_ALU;
    bus.ALUResult = 32'h0000_0006;
    step();
    chk("mis_pc",  bus.PC,              32'h0000_0006);
    chk("mis_set", 32'(bus.PCMisalign), 32'd1);
    bus.ALUResult = 32'h0000_0100;
    step();
    chk("mis_pc2",    bus.PC,              32'h0000_0100);
    chk("mis_sticky", 32'(bus.PCMisalign), 32'd1);

    // Hold select ignores PCWrite.
    bus.PCSrc     = PCSRC_HOLD;
    bus.ALUResult = 32'h0000_0200;
    step();
    chk("hold_pc", bus.PC, 32'h0000_0100);

    // Counter wrap: 2 fetches so far, 14 more reach 16 -> 0.
    idle();
    bus.IRWrite   = 1'b1;
    bus.MemRdData = 32'h2008_FFFF;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 12) chk("cnt_max", 32'(bus.FetchCount), 32'd15);
    end
    chk("cnt_wrap",     32'(bus.FetchCount), 32'd0);
    chk("signimm_neg",  bus.SignImm,         32'hFFFF_FFFF);

    // Async reset between edges.
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.ALUResult = 32'h0000_0300;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pc",      bus.PC,              C_RESET_PC);
    chk("arst_instr",   bus.Instr,           32'h0);
    chk("arst_rt",      32'(bus.Rt),         32'h0);
    chk("arst_mdr",     bus.MemData,         32'h0);
    chk("arst_aluout",  bus.ALUOut,          32'h0);
    chk("arst_cnt",     32'(bus.FetchCount), 32'h0);
    chk("arst_mis",     32'(bus.PCMisalign), 32'h0);
    chk("arst_memaddr", bus.MemAddr,         C_RESET_PC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_datapath
`default_nettype wire

// File: doc/fetch_datapath.md
# fetch_datapath

Multicycle MIPS fetch/sequencing datapath slice sitting directly downstream of the main control FSM and upstream of its `Op` input. It holds the program counter, instruction register, memory data register and ALU output register. It forms the PC enable from `PCWrite`/`Branch`/`NEF`/`Zero`, selects the next PC and the memory address, and decodes the instruction fields fed back to control and the register file. It also keeps a retired-fetch counter and a sticky misaligned-PC flag for debug.

## Interface
- `WIDTH`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `CNT_W`, 32: fetch counter width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PCWrite`  in  1  unconditional PC update.
- `Branch`  in  1  conditional PC update.
- `NEF`  in  1  branch sense: 0 = beq, 1 = bne.
- `Zero`  in  1  ALU zero flag, current cycle.
- `IorD`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  in  1  load IR from memory read data.
- `PCSrc`  in  2  next-PC select.
- `ALUResult`  in  WIDTH  combinational ALU result.
- `MemRdData`  in  WIDTH  memory read data.
- `MemAddr`  out  WIDTH  memory address.
- `PC`  out  WIDTH  current PC.
- `Instr`  out  WIDTH  IR contents.
- `Op`  out  6  `Instr[31:26]`.
- `Rs`, `Rt`, `Rd`  out  5 each  `Instr[25:21]`, `[20:16]`, `[15:11]`.
- `Funct`  out  6  `Instr[5:0]`.
- `SignImm`  out  WIDTH  sign-extended `Instr[15:0]`.
- `MemData`  out  WIDTH  MDR contents.
- `ALUOut`  out  WIDTH  ALU output register.
- `FetchCount`  out  CNT_W  number of IR loads since reset.
- `PCMisalign`  out  1  sticky: PC was loaded with nonzero `[1:0]`.

## Operation
- `PCEn = PCWrite | (Branch & (Zero ^ NEF))`.
  - beq taken when `Zero=1`.
  - bne taken when `Zero=0`.
- Next PC by `PCSrc`:
  - 00: `ALUResult`.
  - 01: `ALUOut`.
  - 10: `{PC[31:28], Instr[25:0], 2'b00}`.
  - 11: PC (hold, even if `PCEn`).
- `MemAddr = IorD ? ALUOut : PC` (combinational).
- IR loads `MemRdData` when `IRWrite`; otherwise holds.
- MDR loads `MemRdData` every cycle.
- ALUOut loads `ALUResult` every cycle.
- `FetchCount` increments by 1 on every cycle with `IRWrite=1` and wraps from all-ones to 0.
- `PCMisalign`:
  - Set when `PCEn` and the selected next PC has `[1:0] != 0`.
  - The PC is still loaded with that value.
  - Cleared only by reset.
- Decode outputs (`Op`, `Rs`, `Rt`, `Rd`, `Funct`, `SignImm`) are combinational from IR.
- No internal FSM: sequencing is owned by the main control. This block must accept any control combination, including illegal ones, without lockup.

## Timing
- Reset (`reset=0`, asynchronous), values held while asserted:
  - PC = `RESET_PC`.
  - IR = 0, so `Op`=0 and all decode outputs are 0.
  - MDR = 0, ALUOut = 0, `FetchCount` = 0, `PCMisalign` = 0.
  - `MemAddr` = `RESET_PC` when `IorD=0`.
- Deassertion: first rising edge after `reset` goes high performs normal updates.
- Registered outputs change one edge after their enable is sampled high.
- `MemAddr` and decode outputs follow their sources in the same cycle.
- Fetch cycle (`IorD=0`, `IRWrite=1`, `PCWrite=1`, `PCSrc=00`, ALU computing PC+4):
  - IR captures the instruction at the old PC.
  - PC becomes old PC+4 on the same edge.
  - `Op` is valid the cycle after.
- Branch: uses `ALUOut`, which holds the target computed the previous cycle. `Zero` is sampled on the same edge as the PC update.
- Reset asserted mid-instruction: all registers return to reset values immediately. No partial update survives.

## Structure
- Shared package `mips_pkg` holds:
  - PCSrc encodings: `PCSRC_ALU`, `PCSRC_ALUOUT`, `PCSRC_JUMP`, `PCSRC_HOLD`.
  - Opcode constants: R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, lw 0x23, sw 0x2B.
  - Default `RESET_PC`.
- One sub-module: `en_reg`, a parameterized-width flop with enable and async active-low reset value. Instantiate it for PC, IR, MDR and ALUOut.
- The counter and sticky flag are written inline.

## Test plan
- Reset with `RESET_PC`=0x0040_0000: hold `reset=0` across edges → PC=0x0040_0000, IR=0, `FetchCount`=0, `PCMisalign`=0; `MemAddr`=0x0040_0000.
- Fetch: `MemRdData`=0x1043_0003 (beq), `ALUResult`=PC+4, fetch controls for one edge → `Instr`=0x1043_0003, `Op`=0x04, `Rs`=2, `Rt`=3, `SignImm`=3, PC=0x0040_0004, `FetchCount`=1.
- Branch taken/not: `ALUOut`=0x0040_0010 then `Branch=1`, `PCSrc=01`, `NEF=0`:
  - `Zero=1` → PC=0x0040_0010.
  - `Zero=0` → PC unchanged.
  - `NEF=1` repeats with the outcomes inverted.
- Jump: IR=0x0800_0040, PC=0x1000_0004, `PCWrite=1`, `PCSrc=10` → PC=0x1000_0100.
- Misalign and hold:
  - `PCWrite=1`, `PCSrc=00`, `ALUResult`=0x0000_0006 → PC=0x0000_0006, `PCMisalign`=1, and it stays 1 after later aligned writes.
  - `PCSrc=11` with `PCWrite=1` → PC holds.
- Counter wrap and async reset: with `CNT_W`=4, 16 `IRWrite` pulses → `FetchCount` returns to 0. Then assert `reset` between edges → all outputs reach reset values before the next edge.
